// File: rtl/ntt_coeff_unpacker_if.sv
// Handshake bundle between the AXI burst write path, the unpacker and the coefficient RAM.
// Latency: none (wires only).
// Backpressure: s_ready and m_ready are carried combinationally.
//
// Signals:
//   s_data/s_valid/s_last/s_ready   packed 32-bit words from the burst write path
//   m_coeff/m_addr/m_valid/m_ready  coefficient writes towards the RAM
// Modports:
//   slave  - unpacker view (sinks words, sources RAM writes)
//   master - view of the environment driving words and absorbing writes
interface ntt_coeff_unpacker_if #(
  parameter int COEFF_W = 12,
  parameter int ADDR_W  = 8
);
  logic [31:0]        s_data;
  logic               s_valid;
  logic               s_last;
  logic               s_ready;
  logic [COEFF_W-1:0] m_coeff;
  logic [ADDR_W-1:0]  m_addr;
  logic               m_valid;
  logic               m_ready;

  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_coeff, m_addr, m_valid
  );

  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_coeff, m_addr, m_valid
  );
endinterface

// File: rtl/ntt_coeff_unpacker.sv
// Unpacks 32-bit words (two COEFF_W coefficients, low half first) into sequential NTT RAM writes.
// Latency: first coefficient one cycle after word acceptance; 1 coeff/cycle sustained.
// Backpressure: s_ready only in EMPTY, or in HOLD_HI combinationally from m_ready; outputs hold while m_ready=0.
//
// Ports:
//   i_aclk, i_areset (async, active high), i_clr (sync clear, wins over a word handshake)
//   io_bus     - word input and RAM write output (ntt_coeff_unpacker_if.slave)
//   o_done     - one-cycle pulse after the write at address N-1
//   o_frame_err- sticky: s_last not on word N/2-1, or word N/2-1 without s_last
//   o_range_err- sticky: a coefficient >= Q was seen (only with COEFF_RANGE_CHECK_EN)
// Optional feature: define COEFF_RANGE_CHECK_EN to reduce coefficients >= Q by one subtraction of Q.
module ntt_coeff_unpacker #(
  parameter int COEFF_W = 12,
  parameter int N       = 256,
  parameter int ADDR_W  = 8,
  parameter int Q       = 3329
) (
  input  logic                i_aclk,
  input  logic                i_areset,
  input  logic                i_clr,
  ntt_coeff_unpacker_if.slave io_bus,
  output logic                o_done,
  output logic                o_frame_err,
  output logic                o_range_err
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_HOLD_LO = 2'd1,
    ST_HOLD_HI = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [COEFF_W-1:0] r_lo;
  logic [COEFF_W-1:0] r_hi;
  logic               r_last;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_done;
  logic               r_frame_err;

  logic               w_s_rdy;
  logic               w_m_vld;
  logic               w_s_acc;
  logic               w_m_acc;
  logic               w_addr_end;
  logic [COEFF_W-1:0] w_raw;
  logic [COEFF_W-1:0] w_coeff;

  assign w_s_acc    = io_bus.s_valid & w_s_rdy;
  // A write coinciding with clr is discarded along with everything else.
  assign w_m_acc    = w_m_vld & io_bus.m_ready & ~i_clr;
  assign w_addr_end = (r_addr == LAST_ADDR);

  // State register
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_state <= ST_EMPTY;
    end else if (i_clr) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY:   if (w_s_acc) w_state_nxt = ST_HOLD_LO;
      ST_HOLD_LO: if (io_bus.m_ready) w_state_nxt = ST_HOLD_HI;
      ST_HOLD_HI: if (io_bus.m_ready) w_state_nxt = w_s_acc ? ST_HOLD_LO : ST_EMPTY;
      default:    w_state_nxt = ST_EMPTY;
    endcase
  end

  // Output logic
  always_comb begin
    w_s_rdy = 1'b0;
    w_m_vld = 1'b0;
    w_raw   = '0;
    case (r_state)
      ST_EMPTY: begin
        w_s_rdy = ~i_clr;
      end
      ST_HOLD_LO: begin
        w_m_vld = 1'b1;
        w_raw   = r_lo;
      end
      ST_HOLD_HI: begin
        w_m_vld = 1'b1;
        w_raw   = r_hi;
        // Refill in the same cycle the high half leaves: no bubble between words.
        w_s_rdy = io_bus.m_ready & ~i_clr;
      end
      default: ;
    endcase
  end

`ifdef COEFF_RANGE_CHECK_EN
  localparam logic [COEFF_W-1:0] Q_W = COEFF_W'(Q);
  logic w_over;
  logic r_range_err;

  // Single conditional subtraction on the output path; values >= 2Q are only partially reduced.
  assign w_over  = (w_raw >= Q_W);
  assign w_coeff = w_over ? (w_raw - Q_W) : w_raw;

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_range_err <= 1'b0;
    end else if (i_clr) begin
      r_range_err <= 1'b0;
    end else if (w_m_acc && w_over) begin
      r_range_err <= 1'b1;
    end
  end
  assign o_range_err = r_range_err;
`else
  assign w_coeff     = w_raw;
  assign o_range_err = 1'b0;
`endif

  // Word register, address counter and flags
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_lo        <= '0;
      r_hi        <= '0;
      r_last      <= 1'b0;
      r_addr      <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
    end else if (i_clr) begin
      r_lo        <= '0;
      r_hi        <= '0;
      r_last      <= 1'b0;
      r_addr      <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_done <= w_m_acc & w_addr_end;
      if (w_s_acc) begin
        r_lo   <= io_bus.s_data[COEFF_W-1:0];
        r_hi   <= io_bus.s_data[16 +: COEFF_W];
        r_last <= io_bus.s_last;
      end
      if (w_m_acc) begin
        // The high half of word N/2-1 always sits at N-1, so the frame check
        // is a comparison of s_last against the address end marker.
        if (r_state == ST_HOLD_HI && (r_last || w_addr_end)) begin
          r_addr <= '0;
        end else begin
          r_addr <= r_addr + 1'b1;
        end
        if (r_state == ST_HOLD_HI && (r_last != w_addr_end)) begin
          r_frame_err <= 1'b1;
        end
      end
    end
  end

  assign io_bus.s_ready = w_s_rdy;
  assign io_bus.m_valid = w_m_vld;
  assign io_bus.m_coeff = w_coeff;
  assign io_bus.m_addr  = r_addr;
  assign o_done         = r_done;
  assign o_frame_err    = r_frame_err;
endmodule

// File: tb/tb_ntt_coeff_unpacker.sv
// Self-checking bench for ntt_coeff_unpacker.
// A queue-based model of the expected write stream is checked every cycle,
// alongside literal expectations for the directed scenarios.
module tb_ntt_coeff_unpacker;
  localparam int COEFF_W = 12;
  localparam int N       = 256;
  localparam int ADDR_W  = 8;
  localparam int Q       = 3329;

  logic clk = 1'b0;
  logic areset;
  logic clr;
  logic done;
  logic frame_err;
  logic range_err;

  ntt_coeff_unpacker_if #(.COEFF_W(COEFF_W), .ADDR_W(ADDR_W)) bus ();

  ntt_coeff_unpacker #(.COEFF_W(COEFF_W), .N(N), .ADDR_W(ADDR_W), .Q(Q)) dut (
    .i_aclk      (clk),
    .i_areset    (areset),
    .i_clr       (clr),
    .io_bus      (bus),
    .o_done      (done),
    .o_frame_err (frame_err),
    .o_range_err (range_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    logic [COEFF_W-1:0] c;
    logic [ADDR_W-1:0]  a;
    bit                 dn;
    bit                 fe;
    bit                 re;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   mc = 0;           // next expected write address
  bit   exp_done = 0;
  bit   m_fe = 0;
  bit   m_re = 0;
  bit   prev_stall = 0;
  logic [COEFF_W-1:0] prev_c;
  logic [ADDR_W-1:0]  prev_a;
  int   cyc = 0;
  int   wr_cnt = 0;
  int   first_wr = -1;
  int   last_wr = -1;
  int   done_cnt = 0;

  function automatic logic [COEFF_W-1:0] fix(input logic [COEFF_W-1:0] v);
`ifdef COEFF_RANGE_CHECK_EN
    if (int'(v) >= Q) return COEFF_W'(int'(v) - Q);
`endif
    return v;
  endfunction

  function automatic bit over(input logic [COEFF_W-1:0] v);
`ifdef COEFF_RANGE_CHECK_EN
    return int'(v) >= Q;
`else
    return (v != v);
`endif
  endfunction

  task automatic model_word(input logic [31:0] d, input logic last);
    exp_t lo;
    exp_t hi;
    bit   at_end;
    at_end = (mc == N - 2);
    lo.c = fix(d[COEFF_W-1:0]);
    lo.a = ADDR_W'(mc);
    lo.dn = 0;
    lo.fe = 0;
    lo.re = over(d[COEFF_W-1:0]);
    hi.c = fix(d[16 +: COEFF_W]);
    hi.a = ADDR_W'(mc + 1);
    hi.dn = at_end;
    hi.fe = (last != at_end);
    hi.re = over(d[16 +: COEFF_W]);
    q.push_back(lo);
    q.push_back(hi);
    mc = (last || at_end) ? 0 : mc + 2;
  endtask

  task automatic model_clear();
    q.delete();
    mc = 0;
    exp_done = 0;
    m_fe = 0;
    m_re = 0;
    prev_stall = 0;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    cyc++;
    if (areset) begin
      model_clear();
    end else begin
      chk("done", done, exp_done);
      chk("frame_err", frame_err, m_fe);
      chk("range_err", range_err, m_re);
      if (done) done_cnt++;
      if (prev_stall) begin
        chk("stall_coeff", bus.m_coeff, prev_c);
        chk("stall_addr", bus.m_addr, prev_a);
        chk("stall_valid", bus.m_valid, 1);
      end
      if (clr) begin
        model_clear();
      end else begin
        exp_done = 0;
        if (bus.m_valid && bus.m_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_write", 1, 0);
          end else begin
            e = q.pop_front();
            chk("wr_coeff", bus.m_coeff, e.c);
            chk("wr_addr", bus.m_addr, e.a);
            exp_done = e.dn;
            m_fe = m_fe | e.fe;
            m_re = m_re | e.re;
          end
          wr_cnt++;
          if (first_wr < 0) first_wr = cyc;
          last_wr = cyc;
        end
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_c = bus.m_coeff;
        prev_a = bus.m_addr;
        if (bus.s_valid && bus.s_ready) model_word(bus.s_data, bus.s_last);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    bit acc;
    acc = 0;
    bus.s_data  = d;
    bus.s_last  = last;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk);
      acc = bus.s_ready;
      tick();
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit idle;
    idle = 0;
    for (int i = 0; i < 64 && !idle; i++) begin
      @(negedge clk);
      idle = !bus.m_valid;
    end
    if (!idle) chk("drain_timeout", 0, 1);
    tick();
    tick();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  function automatic logic [31:0] word_k(input int k);
    logic [31:0] w;
    w = {4'h0, 12'(2 * k + 1), 4'h0, 12'(2 * k)};
    return w;
  endfunction

  task automatic load_frame();
    for (int k = 0; k < N / 2; k++) begin
      send_word(word_k(k), k == N / 2 - 1);
      if (k == 0) begin
        chk("first_lat_valid", bus.m_valid, 1);
        chk("first_lat_coeff", bus.m_coeff, 0);
        chk("first_lat_addr", bus.m_addr, 0);
      end
    end
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    areset      = 1'b1;
    clr         = 1'b0;
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    #1;
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_coeff", bus.m_coeff, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_range_err", range_err, 0);
    tick();
    tick();
    areset = 1'b0;
    chk("rst_s_ready", bus.s_ready, 1);

    // Basic load, back-to-back words with m_ready held high
    bus.m_ready = 1'b1;
    wr_cnt = 0; first_wr = -1; done_cnt = 0;
    load_frame();
    chk("basic_writes", wr_cnt, 256);
    chk("basic_span", last_wr - first_wr, 255);
    chk("basic_done_cnt", done_cnt, 1);
    chk("basic_frame_err", frame_err, 0);

    // Backpressure: m_ready pattern 1,0,0,1 across the two halves
    bus.m_ready = 1'b0;
    wr_cnt = 0;
    send_word(32'h0ABC_0123, 1'b0);
    chk("bp_lo_coeff", bus.m_coeff, 12'h123);
    chk("bp_lo_s_ready", bus.s_ready, 0);
    bus.m_ready = 1'b1;
    tick();
    chk("bp_hi_coeff", bus.m_coeff, 12'hABC);
    bus.m_ready = 1'b0;
    tick();
    chk("bp_stall_s_ready", bus.s_ready, 0);
    tick();
    chk("bp_hi_hold", bus.m_coeff, 12'hABC);
    chk("bp_stall2_s_ready", bus.s_ready, 0);
    bus.m_ready = 1'b1;
    #1;
    chk("bp_hs_s_ready", bus.s_ready, 1);
    tick();
    chk("bp_empty", bus.m_valid, 0);
    chk("bp_writes", wr_cnt, 2);

    // Early s_last on word 5
    do_clr();
    done_cnt = 0;
    for (int k = 0; k < 6; k++) send_word(word_k(k), k == 5);
    send_word(word_k(6), 1'b0);
    chk("early_next_addr", bus.m_addr, 0);
    chk("early_next_coeff", bus.m_coeff, 12);
    drain();
    chk("early_frame_err", frame_err, 1);
    chk("early_no_done", done_cnt, 0);

    // clr with s_valid high in EMPTY
    clr         = 1'b1;
    bus.s_data  = 32'h0555_0444;
    bus.s_valid = 1'b1;
    @(negedge clk);
    chk("clr_s_ready", bus.s_ready, 0);
    tick();
    clr         = 1'b0;
    bus.s_valid = 1'b0;
    chk("clr_not_taken", bus.m_valid, 0);
    chk("clr_frame_err", frame_err, 0);
    tick();
    chk("clr_stays_empty", bus.m_valid, 0);

    // Range check
    do_clr();
    bus.m_ready = 1'b0;
    send_word(32'h0D01_0D02, 1'b0);
`ifdef COEFF_RANGE_CHECK_EN
    chk("range_lo", bus.m_coeff, 12'd1);
`else
    chk("range_lo", bus.m_coeff, 12'hD02);
`endif
    bus.m_ready = 1'b1;
    tick();
`ifdef COEFF_RANGE_CHECK_EN
    chk("range_hi", bus.m_coeff, 12'd0);
`else
    chk("range_hi", bus.m_coeff, 12'hD01);
`endif
    drain();
`ifdef COEFF_RANGE_CHECK_EN
    chk("range_err_flag", range_err, 1);
`else
    chk("range_err_flag", range_err, 0);
`endif

    // Mid-frame asynchronous reset after 40 coefficients, then a full reload
    do_clr();
    wr_cnt = 0;
    for (int k = 0; k < 21; k++) send_word(word_k(k), 1'b0);
    chk("mid_writes", wr_cnt, 40);
    #2;
    areset = 1'b1;
    #1;
    chk("ares_m_valid", bus.m_valid, 0);
    chk("ares_m_addr", bus.m_addr, 0);
    chk("ares_done", done, 0);
    tick();
    tick();
    areset = 1'b0;
    wr_cnt = 0; first_wr = -1; done_cnt = 0;
    load_frame();
    chk("reload_writes", wr_cnt, 256);
    chk("reload_done_cnt", done_cnt, 1);
    chk("reload_frame_err", frame_err, 0);
    chk("model_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ntt_coeff_unpacker.md
Name: ntt_coeff_unpacker

Overview:
Sits between the AXI4 full-slave burst write path of the NTT unit and the NTT coefficient RAM write port. It accepts 32-bit words carrying two packed 12-bit coefficients, unpacks them in order (low half first), and writes each one to the RAM with a sequential address. It tracks polynomial frames of N coefficients, flags framing errors, and pulses done when a full polynomial has been loaded.

Parameters:
COEFF_W, 12, coefficient width in bits; low coefficient at word[COEFF_W-1:0], high coefficient at word[16+COEFF_W-1:16].
N, 256, coefficients per polynomial; even, power of two.
ADDR_W, 8, coefficient address width; equals log2(N).
Q, 3329, modulus used by the optional range check.

Ports:
ACLK  in  1  clock; all logic on rising edge.
ARESET  in  1  asynchronous active-high reset.
clr  in  1  synchronous clear: state, counters and flags go to reset values.
s_data  in  32  packed word from the AXI burst write path.
s_valid  in  1  s_data valid.
s_last  in  1  marks the final word of the polynomial (word N/2-1).
s_ready  out  1  word accepted when s_valid and s_ready are both high.
m_coeff  out  COEFF_W  coefficient to RAM.
m_addr  out  ADDR_W  RAM address of m_coeff.
m_valid  out  1  m_coeff/m_addr valid.
m_ready  in  1  RAM write accepted.
done  out  1  one-cycle pulse when coefficient N-1 is accepted.
frame_err  out  1  sticky framing error.
range_err  out  1  sticky out-of-range coefficient flag (optional feature).

Behaviour:
- Reset (ARESET high, asynchronous, or clr high at the clock edge):
  - state=EMPTY, m_valid=0, m_coeff=0, m_addr=0.
  - done=0, frame_err=0, range_err=0, word register=0.
  - Reset during a frame discards the partial frame; no done is produced.
- State machine:
  - EMPTY: s_ready=1, m_valid=0. Accepting a word latches s_data/s_last into the word register and moves to HOLD_LO.
  - HOLD_LO: m_valid=1, m_coeff=low half, s_ready=0. m_ready moves to HOLD_HI.
  - HOLD_HI: m_valid=1, m_coeff=high half, s_ready=m_ready (combinational). On m_ready: if s_valid, latch the new word and go to HOLD_LO (no bubble); otherwise go to EMPTY.
- Latency and throughput:
  - First coefficient appears one cycle after word acceptance.
  - Sustained rate is 1 coefficient/cycle, 2 cycles/word, when s_valid and m_ready are held high.
- m_coeff, m_addr and m_valid are stable while m_valid=1 and m_ready=0.
- Address counter:
  - Increments on each m_valid&m_ready and wraps N-1 -> 0.
  - done pulses in the cycle after the acceptance at m_addr=N-1.
- Framing:
  - s_last on a word other than word N/2-1: set frame_err. Both halves are still written; the address then forces to 0 after the high half.
  - Word N/2-1 without s_last: set frame_err, wrap normally, no done suppression.
  - frame_err clears only on reset or clr.
- Coefficient extraction:
  - Bits [15:COEFF_W] and [31:16+COEFF_W] are ignored.
  - No arithmetic is applied unless the optional feature is enabled.
- Simultaneous clr and s_valid: clr wins and the word is not accepted (s_ready forced 0 while clr=1).

Optional Feature:
Macro COEFF_RANGE_CHECK_EN.
- Defined: each unpacked coefficient v >= Q is emitted as v-Q (COEFF_W bits, single subtraction) and sets range_err sticky. Values < Q pass unchanged. The compare/subtract sits in the word-register output path and adds no cycles.
- Undefined: coefficients pass through unmodified and range_err is tied to 0.

Test Plan:
- Basic load: 128 words, word k = {4'h0, (2k+1), 4'h0, (2k)}, s_last on word 127, m_ready=1 -> m_coeff 0..255 at m_addr 0..255, one done pulse, frame_err=0, 256 coefficients in 256 cycles after the first.
- Backpressure: m_ready toggles 1,0,0,1 with word 32'h0ABC_0123 -> 0x123 then 0xABC, each held stable through stalls, exactly two writes, s_ready low until the HOLD_HI handshake.
- Early s_last on word 5 -> frame_err=1 after word 5; the next word's low coefficient is written at m_addr=0; no done.
- Range check (macro defined): word 32'h0D01_0D02 (3330, 3329) -> m_coeff 1 and 0, range_err=1. Macro undefined -> 0xD02, 0xD01, range_err=0.
- Mid-frame ARESET after 40 coefficients -> m_valid, m_addr and done go to 0 immediately. Reloading a full frame then gives addresses 0..255 and a single done.
- clr asserted with s_valid high in EMPTY -> word not accepted, state stays EMPTY, frame_err cleared.
